// File: rtl/fetch_unit_pkg.sv
// Shared fetch constants and the {pc, instr} queue entry type.
// The constants are also used by the CPU top and the branch adder.
package fetch_unit_pkg;

  localparam logic [31:0] RESET_PC     = 32'h0000_0000;
  localparam logic [31:0] INSTR_LENGTH = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_fetch_buffer.sv
// Two-entry FIFO of {pc, instr}. Slot 0 is always the head.
// Flush wins over push and pop. Only the occupancy count is reset.
module fetch_buffer
  import fetch_unit_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  fetch_entry_t din_i,
  output fetch_entry_t dout_o,
  output logic [1:0]   count_o
);

  fetch_entry_t ent0_q, ent0_d;
  fetch_entry_t ent1_q, ent1_d;
  logic [1:0]   cnt_q, cnt_d;

  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    cnt_d  = cnt_q;
    if (flush_i) begin
      cnt_d = 2'd0;
    end else begin
      unique case ({push_i, pop_i})
        2'b10: begin
          if (cnt_q == 2'd0) ent0_d = din_i;
          else               ent1_d = din_i;
          cnt_d = cnt_q + 2'd1;
        end
        2'b01: begin
          ent0_d = ent1_q;
          cnt_d  = cnt_q - 2'd1;
        end
        // Simultaneous push and pop: the count is unchanged.
        2'b11: begin
          if (cnt_q == 2'd2) begin
            ent0_d = ent1_q;
            ent1_d = din_i;
          end else begin
            ent0_d = din_i;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= 2'd0;
    else       cnt_q <= cnt_d;
  end

  always_ff @(posedge clk_i) begin
    ent0_q <= ent0_d;
    ent1_q <= ent1_d;
  end

  assign dout_o  = ent0_q;
  assign count_o = cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches from combinational imem,
// queues two {pc, instr} entries, and handles branch redirects.
module fetch_unit
  import fetch_unit_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_instr_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] fetch_cnt_o
);

  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  fetch_cnt_q, fetch_cnt_d;
  logic [1:0]   count;
  logic         push, pop;
  fetch_entry_t head, tail_in;

  assign instr_valid_o = (count != 2'd0) && !redirect_i;
  assign pop           = instr_valid_o && instr_ready_i;
  assign push          = start_i && !redirect_i && ((count < 2'd2) || pop);

  assign tail_in.pc    = fetch_pc_q;
  assign tail_in.instr = imem_instr_i;

  fetch_buffer u_buf (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect_i),
    .din_i   (tail_in),
    .dout_o  (head),
    .count_o (count)
  );

  // Redirect has priority over fetch advance; pop is already gated by it.
  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    fetch_cnt_d = fetch_cnt_q;
    if (redirect_i)  fetch_pc_d = align_pc(redirect_pc_i);
    else if (push)   fetch_pc_d = fetch_pc_q + INSTR_LENGTH;
    if (pop)         fetch_cnt_d = fetch_cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_pc_q  <= RESET_PC;
      fetch_cnt_q <= 32'd0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  assign imem_addr_o = fetch_pc_q;
  assign instr_o     = head.instr;
  assign pc_o        = head.pc;
  assign fetch_cnt_o = fetch_cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a combinational imem model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_i, start_i, redirect_i, instr_ready_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] imem_addr_o, imem_instr_i;
  logic        instr_valid_o;
  logic [31:0] instr_o, pc_o, fetch_cnt_o;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Word differs from its address so pc/instr swaps are visible.
  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  assign imem_instr_i = imem_word(imem_addr_o);

  fetch_unit dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .imem_addr_o   (imem_addr_o),
    .imem_instr_i  (imem_instr_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .instr_o       (instr_o),
    .pc_o          (pc_o),
    .fetch_cnt_o   (fetch_cnt_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_head(input string tag, input logic [31:0] pc, input logic [31:0] addr);
    chk({tag, "_valid"}, {31'd0, instr_valid_o}, 32'd1);
    chk({tag, "_pc"}, pc_o, pc);
    chk({tag, "_instr"}, instr_o, imem_word(pc));
    chk({tag, "_addr"}, imem_addr_o, addr);
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b0; redirect_i = 1'b0;
    redirect_pc_i = 32'd0; instr_ready_i = 1'b0;
    step(); step();
    chk("rst_valid", {31'd0, instr_valid_o}, 32'd0);
    chk("rst_addr", imem_addr_o, 32'h0);
    chk("rst_cnt", fetch_cnt_o, 32'd0);

    // Steady stream: head pc 4*i, fetch one ahead.
    rst_i = 1'b0; start_i = 1'b1; instr_ready_i = 1'b1;
    #1 chk("idle_valid", {31'd0, instr_valid_o}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk_head("stream", 32'(4 * i), 32'(4 * i + 4));
      chk("stream_cnt", fetch_cnt_o, 32'(i));
    end
    step();
    chk_head("stream10", 32'd40, 32'd44);
    chk("cnt10", fetch_cnt_o, 32'd10);

    // Backpressure: queue fills to 2 then fetch stalls at head+8.
    instr_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk_head("bp_hold", 32'd40, 32'd48);
    chk("bp_cnt", fetch_cnt_o, 32'd10);
    instr_ready_i = 1'b1;
    step();
    chk_head("bp_res1", 32'd44, 32'd52);
    chk("bp_res1_cnt", fetch_cnt_o, 32'd11);
    step();
    chk_head("bp_res2", 32'd48, 32'd56);
    chk("bp_res2_cnt", fetch_cnt_o, 32'd12);

    // Redirect with a full queue and ready high.
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_0103;
    #1 chk("redir_gate", {31'd0, instr_valid_o}, 32'd0);
    step();
    redirect_i = 1'b0;
    #1;
    chk("redir_n1_valid", {31'd0, instr_valid_o}, 32'd0);
    chk("redir_n1_addr", imem_addr_o, 32'h100);
    chk("redir_n1_cnt", fetch_cnt_o, 32'd12);
    step();
    chk_head("redir_n2", 32'h100, 32'h104);
    chk("redir_n2_cnt", fetch_cnt_o, 32'd12);

    // Build 2 entries, then drop start and drain.
    step();
    chk_head("pre_drain", 32'h104, 32'h108);
    instr_ready_i = 1'b0;
    step();
    chk_head("fill2", 32'h104, 32'h10C);
    start_i = 1'b0; instr_ready_i = 1'b1;
    step();
    chk_head("drain1", 32'h108, 32'h10C);
    step();
    chk("drain_valid", {31'd0, instr_valid_o}, 32'd0);
    chk("drain_cnt", fetch_cnt_o, 32'd15);
    step();
    chk("frozen_addr", imem_addr_o, 32'h10C);
    start_i = 1'b1;
    step();
    chk_head("resume", 32'h10C, 32'h110);

    // Reset mid-stream with the queue full.
    instr_ready_i = 1'b0;
    step();
    chk("full_addr", imem_addr_o, 32'h114);
    rst_i = 1'b1;
    step();
    chk("mrst_valid", {31'd0, instr_valid_o}, 32'd0);
    chk("mrst_addr", imem_addr_o, 32'h0);
    chk("mrst_cnt", fetch_cnt_o, 32'd0);

    // PC wrap; low address bits of the target are dropped.
    rst_i = 1'b0; instr_ready_i = 1'b1;
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFE;
    step();
    redirect_i = 1'b0;
    #1 chk("wrap_addr", imem_addr_o, 32'hFFFF_FFFC);
    step();
    chk_head("wrap_a", 32'hFFFF_FFFC, 32'h0);
    step();
    chk_head("wrap_b", 32'h0, 32'h4);
    chk("wrap_cnt", fetch_cnt_o, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
